// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM read/write FIFO blocks: burst FSM encoding,
// byte ordering of 16-bit words, and the default burst length of the controller.
package sdram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RECV = 2'd2
  } burst_state_t;

  localparam bit BYTE_ORDER_LOW_FIRST = 1'b1;
  localparam int SDRAM_BURST_LEN      = 8;

  // sel = 0 picks the byte that leaves first, sel = 1 the one that leaves second.
  function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic sel);
    logic hi;
    hi = sel ^ !BYTE_ORDER_LOW_FIRST;
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/sdram_rd_unpack_if.sv
// Bundles the controller read port and the user byte-pop port of the read unpacker.
interface sdram_rd_unpack_if #(
  parameter int DEPTH = 256
);
  localparam int LW = $clog2(DEPTH) + 2;

  // Handshakes: burst_req stays high until the one-cycle burst_ack pulse; every
  // cycle with sdram_rd_valid high carries one beat (no backpressure); a byte is
  // popped on each cycle with fifo_rd_en high and fifo_empty low.
  logic                       rd_enable;
  logic                       burst_req;
  logic                       burst_ack;
  logic                       sdram_rd_valid;
  logic [15:0]                sdram_rd_data;
  logic                       fifo_rd_en;
  logic [7:0]                 fifo_rd_data;
  logic                       fifo_empty;
  logic [LW-1:0]              fifo_level;
  logic                       ovf_err;
  sdram_pkg::burst_state_t    state_dbg;

  modport master (
    input  rd_enable, burst_ack, sdram_rd_valid, sdram_rd_data, fifo_rd_en,
    output burst_req, fifo_rd_data, fifo_empty, fifo_level, ovf_err, state_dbg
  );

  modport slave (
    output rd_enable, burst_ack, sdram_rd_valid, sdram_rd_data, fifo_rd_en,
    input  burst_req, fifo_rd_data, fifo_empty, fifo_level, ovf_err, state_dbg
  );

endinterface

// File: rtl/sdram_sp_ram.sv
// Simple dual-port word store: one synchronous write port, one asynchronous read port.
module sdram_sp_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sdram_rd_unpack.sv
// Requests fixed-length SDRAM read bursts, buffers the 16-bit beats and hands
// them out as bytes, first byte of each word first.
module sdram_rd_unpack
  import sdram_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int BURST_LEN = SDRAM_BURST_LEN
) (
  input  logic              clk,
  input  logic              rst,
  sdram_rd_unpack_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = AW + 2;
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [PW-1:0] DEPTH_W   = PW'(DEPTH);
  localparam logic [PW:0]   DEPTH_X   = (PW+1)'(DEPTH);
  localparam logic [PW:0]   BURST_X   = (PW+1)'(BURST_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  burst_state_t  state_q;
  logic          burst_req_q;
  logic [CW-1:0] beat_cnt_q;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          byte_sel_q, byte_sel_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          ovf_err_q, ovf_err_d;

  logic [PW-1:0] used;
  logic [PW:0]   outstanding;
  logic [PW:0]   committed;
  logic [LW-1:0] level;
  logic          can_request;
  logic          has_space;
  logic          push;
  logic          drop;
  logic          pop;
  logic [15:0]   rd_word;

  // Beats still owed by the current burst are reserved so a compliant
  // controller can never overrun the buffer.
  assign used        = wr_ptr_q - rd_ptr_q;
  assign outstanding = (state_q == ST_RECV) ? (BURST_X - (PW+1)'(beat_cnt_q)) : '0;
  assign committed   = {1'b0, used} + outstanding;
  assign can_request = (committed + BURST_X) <= DEPTH_X;

  assign has_space = used < DEPTH_W;
  assign push      = bus.sdram_rd_valid && (state_q == ST_RECV) && has_space;
  assign drop      = bus.sdram_rd_valid && !push;
  assign level     = {used, 1'b0} - LW'(byte_sel_q);
  assign pop       = bus.fifo_rd_en && (level != '0);

  sdram_sp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (bus.sdram_rd_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      burst_req_q <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.rd_enable && can_request) begin
            state_q     <= ST_REQ;
            burst_req_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus.burst_ack) begin
            state_q     <= ST_RECV;
            burst_req_q <= 1'b0;
            beat_cnt_q  <= '0;
          end
        end
        ST_RECV: begin
          // beat_cnt_q is the index of the beat currently arriving.
          if (bus.sdram_rd_valid) begin
            if (beat_cnt_q == LAST_BEAT) state_q <= ST_IDLE;
            else                         beat_cnt_q <= beat_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          burst_req_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    byte_sel_d = byte_sel_q;
    rd_data_d  = rd_data_q;
    ovf_err_d  = ovf_err_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) begin
      rd_data_d  = pick_byte(rd_word, byte_sel_q);
      byte_sel_d = !byte_sel_q;
      if (byte_sel_q) rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (drop) ovf_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      byte_sel_q <= 1'b0;
      rd_data_q  <= 8'h00;
      ovf_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      byte_sel_q <= byte_sel_d;
      rd_data_q  <= rd_data_d;
      ovf_err_q  <= ovf_err_d;
    end
  end

  assign bus.burst_req    = burst_req_q;
  assign bus.fifo_rd_data = rd_data_q;
  assign bus.fifo_level   = level;
  assign bus.fifo_empty   = (level == '0);
  assign bus.ovf_err      = ovf_err_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_sdram_rd_unpack.sv
// Bench for sdram_rd_unpack: directed vector table, hand-written corner sequences,
// and a randomized run checked against a byte-queue reference model.
module tb_sdram_rd_unpack;
  import sdram_pkg::*;

  localparam int DEPTH     = 256;
  localparam int BURST_LEN = 8;
  localparam int LW        = $clog2(DEPTH) + 2;
  localparam int NV        = 28;

  logic clk;
  logic rst;

  sdram_rd_unpack_if #(.DEPTH(DEPTH)) u_if ();

  sdram_rd_unpack #(
    .DEPTH     (DEPTH),
    .BURST_LEN (BURST_LEN)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.master)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int         n_vec;
  int         n_err;
  logic [7:0] exp_q[$];
  logic [7:0] exp_last;
  logic [15:0] word_ctr;

  typedef struct packed {
    logic          en;
    logic          ack;
    logic          valid;
    logic [15:0]   data;
    logic          rd_en;
    logic          exp_req;
    logic          exp_empty;
    logic [LW-1:0] exp_level;
    logic [7:0]    exp_data;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    u_if.burst_ack      = 1'b0;
    u_if.sdram_rd_valid = 1'b0;
    u_if.sdram_rd_data  = 16'h0000;
    u_if.fifo_rd_en     = 1'b0;
  endtask

  // One clock with the given inputs; the model decides acceptance through 'accept'.
  task automatic cycle(input logic en, input logic ack, input logic valid,
                       input logic [15:0] data, input logic accept, input logic pop);
    logic popped;
    u_if.rd_enable      = en;
    u_if.burst_ack      = ack;
    u_if.sdram_rd_valid = valid;
    u_if.sdram_rd_data  = data;
    u_if.fifo_rd_en     = pop;
    popped = pop && (exp_q.size() != 0);
    if (popped) exp_last = exp_q.pop_front();
    if (valid && accept) begin
      exp_q.push_back(data[7:0]);
      exp_q.push_back(data[15:8]);
    end
    step();
    check("rd_data", 32'(u_if.fifo_rd_data), 32'(exp_last));
    check("level", 32'(u_if.fifo_level), 32'(exp_q.size()));
    check("empty", 32'(u_if.fifo_empty), 32'(exp_q.size() == 0));
    idle_inputs();
  endtask

  task automatic wait_req(input logic en, input string name);
    int n;
    n = 0;
    while (!u_if.burst_req && n < 10) begin
      cycle(en, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      n++;
    end
    check(name, 32'(u_if.burst_req), 32'd1);
  endtask

  task automatic send_burst(input logic en);
    cycle(en, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < BURST_LEN; i++) begin
      cycle(en, 1'b0, 1'b1, word_ctr, 1'b1, 1'b0);
      word_ctr = word_ctr + 16'd1;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle_inputs();
    u_if.rd_enable = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    exp_last = 8'h00;
  endtask

  // ---------------- random-phase variables ----------------
  int          ctl_left;
  int          ack_wait;
  logic        r_valid;
  logic        r_ack;
  logic        r_pop;
  logic [15:0] r_data;

  initial begin
    n_vec    = 0;
    n_err    = 0;
    word_ctr = 16'h1000;
    exp_last = 8'h00;
    rst      = 1'b1;
    u_if.rd_enable = 1'b0;
    idle_inputs();

    // Vector table: first burst, second request, then pop the 16 bytes.
    for (int i = 0; i < NV; i++) vecs[i] = '0;
    vecs[0].en = 1'b1; vecs[0].exp_req = 1'b1; vecs[0].exp_empty = 1'b1;
    vecs[1].en = 1'b1; vecs[1].ack = 1'b1; vecs[1].exp_empty = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vecs[2+i].en        = 1'b1;
      vecs[2+i].valid     = 1'b1;
      vecs[2+i].data      = 16'h0100 + 16'(i);
      vecs[2+i].exp_level = LW'(2 * (i + 1));
    end
    vecs[10].en = 1'b1; vecs[10].exp_req = 1'b1; vecs[10].exp_level = LW'(16);
    for (int k = 0; k < 16; k++) begin
      vecs[11+k].rd_en     = 1'b1;
      vecs[11+k].exp_req   = 1'b1;
      vecs[11+k].exp_level = LW'(15 - k);
      vecs[11+k].exp_empty = (k == 15);
      vecs[11+k].exp_data  = (k % 2 == 0) ? 8'(k / 2) : 8'h01;
    end
    vecs[27].rd_en = 1'b1; vecs[27].exp_req = 1'b1; vecs[27].exp_empty = 1'b1;
    vecs[27].exp_data = 8'h01;

    // Reset values, held during reset.
    step();
    step();
    check("rst_req", 32'(u_if.burst_req), 32'd0);
    check("rst_data", 32'(u_if.fifo_rd_data), 32'h00);
    check("rst_empty", 32'(u_if.fifo_empty), 32'd1);
    check("rst_level", 32'(u_if.fifo_level), 32'd0);
    check("rst_ovf", 32'(u_if.ovf_err), 32'd0);
    check("rst_state", 32'(u_if.state_dbg), 32'(ST_IDLE));
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      u_if.rd_enable      = vecs[i].en;
      u_if.burst_ack      = vecs[i].ack;
      u_if.sdram_rd_valid = vecs[i].valid;
      u_if.sdram_rd_data  = vecs[i].data;
      u_if.fifo_rd_en     = vecs[i].rd_en;
      step();
      check($sformatf("tbl%0d_req", i), 32'(u_if.burst_req), 32'(vecs[i].exp_req));
      check($sformatf("tbl%0d_empty", i), 32'(u_if.fifo_empty), 32'(vecs[i].exp_empty));
      check($sformatf("tbl%0d_level", i), 32'(u_if.fifo_level), 32'(vecs[i].exp_level));
      check($sformatf("tbl%0d_data", i), 32'(u_if.fifo_rd_data), 32'(vecs[i].exp_data));
      check($sformatf("tbl%0d_ovf", i), 32'(u_if.ovf_err), 32'(vecs[i].exp_ovf));
    end
    idle_inputs();
    exp_last = 8'h01;

    // Pending request is acknowledged; the burst carries one extra beat.
    cycle(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < BURST_LEN; i++)
      cycle(1'b0, 1'b0, 1'b1, 16'h0200 + 16'(i), 1'b1, 1'b0);
    check("ovf_before_extra", 32'(u_if.ovf_err), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    check("ovf_extra_beat", 32'(u_if.ovf_err), 32'd1);
    for (int i = 0; i < 2 * BURST_LEN; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      check("no_req_disabled", 32'(u_if.burst_req), 32'd0);
    end

    // Reset during the 4th beat of a burst.
    wait_req(1'b1, "req_before_rst");
    cycle(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 16'h0300 + 16'(i), 1'b1, 1'b0);
    u_if.rd_enable      = 1'b0;
    u_if.sdram_rd_valid = 1'b1;
    u_if.sdram_rd_data  = 16'h0303;
    rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(u_if.burst_req), 32'd0);
    check("mid_rst_data", 32'(u_if.fifo_rd_data), 32'h00);
    check("mid_rst_empty", 32'(u_if.fifo_empty), 32'd1);
    check("mid_rst_level", 32'(u_if.fifo_level), 32'd0);
    check("mid_rst_ovf", 32'(u_if.ovf_err), 32'd0);
    idle_inputs();
    step();
    rst = 1'b0;
    exp_q.delete();
    exp_last = 8'h00;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      check("no_req_after_rst", 32'(u_if.burst_req), 32'd0);
    end
    wait_req(1'b1, "req_after_rst");

    // Fill to DEPTH words with no pops.
    for (int b = 0; b < DEPTH / BURST_LEN; b++) begin
      wait_req(1'b1, "fill_req");
      send_burst(1'b1);
    end
    check("full_level", 32'(u_if.fifo_level), 32'(2 * DEPTH));
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      check("no_req_full", 32'(u_if.burst_req), 32'd0);
    end
    for (int i = 0; i < 2 * BURST_LEN; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      check("no_req_popping", 32'(u_if.burst_req), 32'd0);
    end
    wait_req(1'b1, "refill_req");
    send_burst(1'b1);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      check("one_refill_only", 32'(u_if.burst_req), 32'd0);
    end
    check("refull_level", 32'(u_if.fifo_level), 32'(2 * DEPTH));

    // Beat while idle and full: dropped, data order intact on drain.
    cycle(1'b0, 1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0);
    check("ovf_idle_beat", 32'(u_if.ovf_err), 32'd1);
    for (int i = 0; i < 2 * DEPTH; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    check("drained_empty", 32'(u_if.fifo_empty), 32'd1);

    // Randomized traffic against the reference queue.
    reset_dut();
    ctl_left = 0;
    ack_wait = 0;
    for (int c = 0; c < 4000; c++) begin
      r_valid = 1'b0;
      r_ack   = 1'b0;
      r_data  = 16'h0000;
      if (ctl_left > 0) begin
        r_valid = ($urandom_range(0, 3) != 0);
        if (r_valid) begin
          r_data = 16'($urandom);
          ctl_left--;
        end
      end else if (u_if.burst_req) begin
        if (ack_wait == 0) begin
          r_ack    = 1'b1;
          ctl_left = BURST_LEN;
          ack_wait = $urandom_range(0, 3);
        end else begin
          ack_wait--;
        end
      end else begin
        r_ack = ($urandom_range(0, 19) == 0);
      end
      r_pop = (c < 1500) ? 1'b1 : ($urandom_range(0, 9) < 4);
      cycle(1'b1, r_ack, r_valid, r_data, 1'b1, r_pop);
    end
    check("ovf_random", 32'(u_if.ovf_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
